alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. It registers operands and commands behind a valid/ready interface and keeps the existing eight-command set and flag semantics at any `WIDTH`. It adds logical and arithmetic shifts and an optional iterative shift-add multiplier. It sits between the decode/operand-fetch stage and write-back, and carries back-pressure in both directions.

## Interface
- `WIDTH`, default 32: operand and result width; must be at least 4 and a power of two.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `in_valid` input, 1 bit: the upstream stage presents an operation.
- `in_ready` output, 1 bit: the block accepts the operation this cycle.
- `command` input, 4 bits: operation code (see Operation).
- `operandA`, `operandB` input, `WIDTH` bits each: operands.
- `out_valid` output, 1 bit: the result and flags are valid.
- `out_ready` input, 1 bit: the downstream stage consumes the result.
- `result` output, `WIDTH` bits: registered result.
- `carryout`, `zero`, `overflow` output, 1 bit each: registered flags.

## Operation
- Command codes:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
  - 8 SLL, 9 SRL, 10 SRA.
  - 11 MUL.
  - 12–15 are unsupported.
- ADD/SUB:
  - Two's complement arithmetic. SUB is computed as A + ~B + 1.
  - `carryout` is the adder carry out of bit `WIDTH-1`. For SUB, carry = 1 means no borrow (A ≥ B unsigned).
  - `overflow` is signed overflow: the operands have equal sign (for SUB, after inverting B) and the result sign differs.
- SLT: `result` = 1 if A < B signed, else 0. It is computed as sign(A−B) XOR overflow(A−B). `carryout` and `overflow` are 0.
- Logic ops: bitwise. `carryout` and `overflow` are 0.
- Shifts:
  - The shift amount is `operandB[$clog2(WIDTH)-1:0]`; upper bits of B are ignored.
  - SRA replicates A's MSB.
  - `carryout` and `overflow` are 0.
- MUL:
  - `result` is the low `WIDTH` bits of the unsigned product A×B.
  - `carryout` = 1 if any bit of the high half of the product is nonzero.
  - `overflow` is 0.
- Unsupported codes: `result` = 0, `zero` = 1, `carryout` = 0, `overflow` = 0. Single-cycle latency.
- `zero` = (`result` == 0) for every command.
- FSM states:
  - IDLE: `in_ready` = 1.
  - MUL: iterating; `in_ready` = 0.
  - DONE: `out_valid` = 1.
- FSM transitions:
  - IDLE to DONE on accepting a non-MUL command.
  - IDLE to MUL on accepting MUL.
  - MUL to DONE when the iteration counter reaches `WIDTH`.
  - DONE to IDLE on `out_ready` with no new accept.
  - DONE stays DONE on `out_ready` && `in_valid` with a non-MUL command (back-to-back).
  - DONE to MUL on `out_ready` && `in_valid` with MUL.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`).
- An accept occurs on `in_valid` && `in_ready` at a rising edge. `in_valid` without `in_ready` has no effect, and the upstream stage holds the operation.
- In DONE with `out_ready` = 0, `result` and all flags hold stable.

## Timing
- Reset: `rst_n` = 0 at a rising edge forces IDLE and clears `out_valid`, `result`, `carryout`, `zero`, `overflow` to 0, plus the iteration counter.
  - Reset takes effect from any state, including mid-MUL, where the partial product is discarded.
  - `in_ready` reads 0 while `rst_n` is low and 1 in the first cycle after release.
- Non-MUL latency: the accepting edge loads `result` and the flags, and `out_valid` is high in the next cycle (1 cycle).
- MUL latency:
  - The accepting edge loads the multiplicand, the multiplier and counter = 0.
  - Each following edge performs one conditional add and shift.
  - The `WIDTH`-th iteration edge loads `result` and the flags and sets `out_valid`.
  - Latency is `WIDTH` + 1 cycles.
- Throughput: one non-MUL operation per cycle under continuous `out_ready`.
- `carryout` for MUL is accumulated across iterations in a 2·`WIDTH` product register; it is never derived from a combinational multiply.

## Configuration
- Macro: `ALU_SEQ_MUL_EN`.
- Defined: the MUL command, MUL state, iteration counter and product register are compiled in.
- Undefined:
  - Code 11 behaves exactly as an unsupported code (single cycle, `result` 0, `zero` 1).
  - The MUL state is unreachable and not built.
  - Everything else is unchanged.

## Structure
- Package `alu_pkg`:
  - the 4-bit command localparams (`CMD_ADD` … `CMD_MUL`);
  - the FSM state enum (IDLE, MUL, DONE);
  - the flag-bundle typedef {carryout, zero, overflow}.
- Sub-module `alu_core`: purely combinational `WIDTH`-parametrised datapath for all single-cycle commands, producing the result and flags.
- The `alu_seq` top contains the FSM, the handshake, the output registers and the `ALU_SEQ_MUL_EN`-guarded iterative multiplier.

## Test plan
- `WIDTH`=32, ADD 1+2, `out_ready` = 1: `out_valid` one cycle after accept; `result` = 3, `carryout`/`zero`/`overflow` = 0 0 0.
- ADD 0x7FFFFFFF+1 gives 0x80000000 with `overflow` 1, `carryout` 0. SUB 3−3 gives 0 with `carryout` 1, `zero` 1. SUB 0x80000000−1 gives 0x7FFFFFFF with `carryout` 1, `overflow` 1.
- SLT 0xFFFFFFFF,1 gives 1. SLT 0x80000000,0x7FFFFFFF gives 1. SLT 1,0xFFFFFFFF gives 0. SRA 0x80000000 by 4 gives 0xF8000000. SLL 1 with B = 0x21 gives 2.
- MUL 0x10000×0x10000 (macro on) gives `result` 0, `carryout` 1, `zero` 1, with `out_valid` exactly 33 cycles after accept. With the macro off, the same stimulus gives `result` 0, `zero` 1, `carryout` 0 after 1 cycle.
- MUL accepted, then `rst_n` low at iteration 10: next cycle `out_valid` 0 and all outputs 0. After release, `in_ready` is 1 and ADD 5+5 gives 10.
- Back-pressure:
  - With `out_ready` held 0 for 5 cycles, the result is stable and `in_ready` is 0.
  - Then `out_ready` = 1 and `in_valid` = 1 (XOR 0xF0,0xFF) in the same cycle: the old result is consumed and the new `result` 0x0F appears the next cycle with no bubble.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: command codes, FSM states
// and the registered flag bundle.
package alu_pkg;

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_XOR  = 4'd2;
    localparam logic [3:0] CMD_SLT  = 4'd3;
    localparam logic [3:0] CMD_AND  = 4'd4;
    localparam logic [3:0] CMD_NAND = 4'd5;
    localparam logic [3:0] CMD_NOR  = 4'd6;
    localparam logic [3:0] CMD_OR   = 4'd7;
    localparam logic [3:0] CMD_SLL  = 4'd8;
    localparam logic [3:0] CMD_SRL  = 4'd9;
    localparam logic [3:0] CMD_SRA  = 4'd10;
    localparam logic [3:0] CMD_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carryout;
        logic zero;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for every single-cycle command.
// Ports: i_cmd, i_a, i_b in; o_result, o_flags {carryout,zero,overflow} out.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_cmd,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    localparam int SW = $clog2(WIDTH);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_o;

    // SLT reuses the subtractor: sign(A-B) ^ overflow(A-B)
    assign w_sub   = (i_cmd == CMD_SUB) || (i_cmd == CMD_SLT);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign {w_cout, w_sum} = {1'b0, i_a} + {1'b0, w_b_eff}
                           + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1])
                  && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    assign w_shamt = i_b[SW-1:0];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        case (i_cmd)
            CMD_ADD, CMD_SUB: begin
                w_res = w_sum;
                w_c   = w_cout;
                w_o   = w_ovf;
            end
            CMD_XOR:  w_res = i_a ^ i_b;
            CMD_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            CMD_AND:  w_res = i_a & i_b;
            CMD_NAND: w_res = ~(i_a & i_b);
            CMD_NOR:  w_res = ~(i_a | i_b);
            CMD_OR:   w_res = i_a | i_b;
            CMD_SLL:  w_res = i_a << w_shamt;
            CMD_SRL:  w_res = i_a >> w_shamt;
            CMD_SRA:  w_res = $signed(i_a) >>> w_shamt;
            // MUL is handled by the top; unsupported codes give zero
            default:  w_res = '0;
        endcase
    end

    assign o_result = w_res;
    assign o_flags  = {w_c, ~|w_res, w_o};

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with shifts and optional iterative multiplier.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, command,
//   operandA, operandB upstream; out_valid/out_ready, result, carryout,
//   zero, overflow downstream. Macro ALU_SEQ_MUL_EN builds the multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);

    state_t           r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;
    logic [WIDTH-1:0] w_core_res;
    flags_t           w_core_flags;
    logic             w_accept;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_cmd    (command),
        .i_a      (operandA),
        .i_b      (operandB),
        .o_result (w_core_res),
        .o_flags  (w_core_flags)
    );

    assign in_ready = rst_n && ((r_state == ST_IDLE)
                   || (r_state == ST_DONE && out_ready));
    assign w_accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    assign w_prod_nxt = r_mplier[0] ? r_prod + r_mcand : r_prod;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_core_res;
                        r_flags  <= w_core_flags;
`ifdef ALU_SEQ_MUL_EN
                        // later assignments override the single-cycle load
                        if (command == CMD_MUL) begin
                            r_state  <= ST_MUL;
                            r_valid  <= 1'b0;
                            r_mcand  <= {{WIDTH{1'b0}}, operandA};
                            r_mplier <= operandB;
                            r_prod   <= '0;
                            r_cnt    <= '0;
                        end
`endif
                    end else if (r_state == ST_DONE && out_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_prod_nxt[WIDTH-1:0];
                        r_flags  <= {|w_prod_nxt[2*WIDTH-1:WIDTH],
                                     ~|w_prod_nxt[WIDTH-1:0], 1'b0};
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign carryout  = r_flags.carryout;
    assign zero      = r_flags.zero;
    assign overflow  = r_flags.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32: directed corner cases,
// back-pressure, reset mid-operation, and randomized traffic.
module tb_alu_seq;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   command = 4'd0;
    logic [W-1:0] operandA = '0;
    logic [W-1:0] operandB = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carryout;
    logic         zero;
    logic         overflow;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .command   (command),
        .operandA  (operandA),
        .operandB  (operandB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         o;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endfunction

    // Reference computed from the arithmetic definition of each command
    function automatic exp_t model(logic [3:0] c, logic [W-1:0] a,
                                   logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.r = '0;
        e.c = 1'b0;
        e.o = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (c)
            4'd0: begin
                p = {32'b0, a} + {32'b0, b};
                e.r = p[31:0];
                e.c = p[32];
                s = sa + sb;
                e.o = (s > SMAX) || (s < SMIN);
            end
            4'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                s = sa - sb;
                e.o = (s > SMAX) || (s < SMIN);
            end
            4'd2:  e.r = a ^ b;
            4'd3:  e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  e.r = a & b;
            4'd5:  e.r = ~(a & b);
            4'd6:  e.r = ~(a | b);
            4'd7:  e.r = a | b;
            4'd8:  e.r = a << b[4:0];
            4'd9:  e.r = a >> b[4:0];
            4'd10: e.r = $signed(a) >>> b[4:0];
`ifdef ALU_SEQ_MUL_EN
            4'd11: begin
                p = {32'b0, a} * {32'b0, b};
                e.r = p[31:0];
                e.c = (p[63:32] != 0);
                e.lat = W + 1;
            end
`endif
            default: e.r = '0;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    // Monitor: latency on first sight, value every valid cycle
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid got 1 exp 0");
            end else begin
                if (!seen) begin
                    seen = 1;
                    chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                end
                chk("result_flags", {result, carryout, zero, overflow},
                    {q[0].r, q[0].c, q[0].z, q[0].o});
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end else begin
                    chk("in_ready_bp", 64'(in_ready), 64'd0);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic issue(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b,
                         bit rnd);
        exp_t e;
        int   n = 0;
        e = model(c, a, b);
        in_valid = 1'b1;
        command  = c;
        operandA = a;
        operandB = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            e.acc = cyc + 1;
            q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready 0 exp 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        q.delete();
        seen = 0;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                    32'h80000000, 32'h10000};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outputs", {out_valid, result, carryout, zero, overflow}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        issue(4'd0, 32'd1, 32'd2, 0);
        issue(4'd0, 32'h7FFFFFFF, 32'd1, 0);
        issue(4'd1, 32'd3, 32'd3, 0);
        issue(4'd1, 32'h80000000, 32'd1, 0);
        issue(4'd3, 32'hFFFFFFFF, 32'd1, 0);
        issue(4'd3, 32'h80000000, 32'h7FFFFFFF, 0);
        issue(4'd3, 32'd1, 32'hFFFFFFFF, 0);
        issue(4'd10, 32'h80000000, 32'd4, 0);
        issue(4'd8, 32'd1, 32'h21, 0);
        issue(4'd11, 32'h10000, 32'h10000, 0);
        issue(4'd13, 32'h1234, 32'h5678, 0);
        drain();

        // back-pressure, then consume and accept in the same cycle
        out_ready = 1'b0;
        issue(4'd0, 32'd20, 32'd22, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(4'd2, 32'hF0, 32'hFF, 0);
        drain();

        // reset in the middle of a multiply
        issue(4'd11, 32'h1234, 32'h5678, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        q.delete();
        seen = 0;
        @(negedge clk);
        chk("rst_low_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midop_rst_outputs", {out_valid, result, carryout, zero, overflow},
            64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(4'd0, 32'd5, 32'd5, 0);
        drain();

        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), rand_op(), rand_op(), 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
